filt_cic_dec_mc: RTL and testbench
==================================

// Module: filt_cic_dec_mc
// PURPOSE
//  Multi-channel, time-multiplexed CIC decimator; next generation of the single-channel CIC block.
//  One shared integrator/comb datapath serves all channels. Per-channel state is held in register arrays.
//  Decimation factor and output scaling are run-time programmable.
//  Output is rounded, saturated and carries a valid strobe and a channel tag.
//  Sits between the sigma-delta/ADC front end and the half-band/FIR decimation chain.
// PARAMETERS
//  gp_nr_channels     2   number of TDM channels (>=1)
//  gp_order           3   CIC order N (integrator and comb stages)
//  gp_diff_delay      1   differential delay M (1 or 2)
//  gp_max_decimation  16  largest supported R; sets accumulator growth
//  gp_inp_width       8   signed input width
//  gp_oup_width       16  signed output width after scaling and saturation
//  gp_acc_width       gp_inp_width+gp_order*$clog2(gp_max_decimation*gp_diff_delay)   internal width (derived)
// PORTS
//  i_clk             in   1                              clock
//  i_rst             in   1                              asynchronous, active-high reset
//  i_cfg_load        in   1                              sync pulse: latch cfg and clear all channel state
//  i_cfg_decimation  in   $clog2(gp_max_decimation)+1    R; 0/1 -> 1, >max -> max
//  i_cfg_shift       in   $clog2(gp_acc_width)           arithmetic right shift before rounding
//  i_valid           in   1                              input sample strobe
//  i_chan            in   $clog2(gp_nr_channels) (min 1) channel of i_data
//  i_data            in   gp_inp_width                   signed input sample
//  o_valid           out  1                              decimated output strobe (1 cycle)
//  o_chan            out  $clog2(gp_nr_channels) (min 1) channel of o_data
//  o_data            out  gp_oup_width                   signed decimated output
//  o_sat             out  1                              o_data was clipped (qualified by o_valid)
// BEHAVIOUR
//  - Reset (async, active-high): all integrator, comb-delay, counter and cfg registers go to 0.
//    Cfg resets to R=1, shift=0. Outputs o_valid=0, o_chan=0, o_data=0, o_sat=0.
//  - Reset asserted mid-stream aborts any in-flight output. No o_valid follows the reset.
//  - Input:
//    - Accept at most one sample per cycle; no backpressure.
//    - i_valid with i_chan>=gp_nr_channels is ignored and does not change state.
//    - Channels may arrive in any order and at any rate.
//  - Integrators:
//    - On accept, channel i_chan's N integrators update as a chained add in the same cycle.
//    - Input is sign-extended to gp_acc_width. Arithmetic is modulo 2^gp_acc_width (wrap is legal).
//  - Decimation:
//    - Each channel has its own counter cnt[c] in 0..R-1. It increments on each accepted sample of that channel.
//    - The sample accepted while cnt[c]==R-1 is decimated, and cnt[c] wraps to 0.
//  - Pipeline:
//    - Cycle T: decimated accept.
//    - Cycle T+1: last-integrator value and channel are registered.
//    - Combs: N stages computed combinationally from that register and channel c's comb-delay array (depth M per stage).
//    - Comb-delay arrays shift only on that channel's decimated sample.
//  - Scaling:
//    - Scaled value = (comb_out + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
//    - The rounding add is computed at gp_acc_width+1 bits.
//    - The result is then saturated to [-2^(gp_oup_width-1), 2^(gp_oup_width-1)-1]. o_sat=1 when clipped.
//  - Output: registered at T+2 with o_valid=1 and o_chan=c. Latency is exactly 2 cycles from i_valid.
//    Back-to-back decimated samples on different channels give back-to-back o_valid.
//  - Cfg load:
//    - On i_cfg_load=1, R and shift are latched (clamped).
//    - All integrators, comb delays and counters are cleared, and the in-flight pipeline stage is squashed.
//    - o_valid=0 next cycle.
//    - i_valid in the same cycle as i_cfg_load is dropped (load wins).
//  - Cfg ports are ignored when i_cfg_load=0. Changing them without a load has no effect.
// TESTING
//  1. ch0 impulse +1 then zeros; R=4, N=3, M=1, shift=0 -> ch0 outputs 10, 6, 0, 0. o_valid 2 cycles after every 4th sample.
//  2. DC +1 on ch0; R=4, shift=6 -> output settles to 1; shift=0 -> settles to 64; o_sat=0.
//  3. DC -128; R=16, N=3, oup 16b, shift=0 -> o_data=-32768, o_sat=1. shift=4 -> -32768 (exact, o_sat=0).
//  4. ch0=+1 and ch1=-1 interleaved every cycle; R=4 -> ch0 and ch1 each settle to +64 and -64 respectively (-64 on ch1).
//     o_chan alternates; no cross-talk.
//  5. i_cfg_load together with i_valid mid-stream, new R=2 -> sample dropped, no o_valid for the squashed stage.
//     Impulse response then restarts from zero state.
//  6. i_rst pulse mid-frame, and i_chan=gp_nr_channels input -> all outputs 0 and no stale o_valid.
//     The invalid channel is ignored.

Source files
------------

// File: rtl/filt_cic_dec_mc.sv
// Multi-channel time-multiplexed CIC decimator.
// One shared integrator/comb datapath; per-channel integrators, comb delays and
// decimation counters live in register arrays indexed by the channel tag.
// The output is rounded, arithmetically shifted, saturated and tagged with its channel.
module filt_cic_dec_mc #(
  parameter int gp_nr_channels    = 2,
  parameter int gp_order          = 3,
  parameter int gp_diff_delay     = 1,
  parameter int gp_max_decimation = 16,
  parameter int gp_inp_width      = 8,
  parameter int gp_oup_width      = 16,
  parameter int gp_acc_width      = gp_inp_width + gp_order * $clog2(gp_max_decimation * gp_diff_delay),
  localparam int lp_dec_width     = $clog2(gp_max_decimation) + 1,
  localparam int lp_shift_width   = $clog2(gp_acc_width),
  localparam int lp_chan_width    = (gp_nr_channels > 1) ? $clog2(gp_nr_channels) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_cfg_load,
  input  logic [lp_dec_width-1:0]          i_cfg_decimation,
  input  logic [lp_shift_width-1:0]        i_cfg_shift,
  input  logic                             i_valid,
  input  logic [lp_chan_width-1:0]         i_chan,
  input  logic signed [gp_inp_width-1:0]   i_data,
  output logic                             o_valid,
  output logic [lp_chan_width-1:0]         o_chan,
  output logic signed [gp_oup_width-1:0]   o_data,
  output logic                             o_sat
);

  localparam int lp_ext_width = gp_acc_width + 1;
  localparam logic signed [lp_ext_width-1:0] lp_oup_max = lp_ext_width'((1 << (gp_oup_width - 1)) - 1);
  localparam logic signed [lp_ext_width-1:0] lp_oup_min = ~lp_oup_max;

  // Configuration; R is held as R-1 so that the all-zero reset value means R=1
  logic [lp_dec_width-1:0]          cfg_rm1_reg;
  logic [lp_dec_width-1:0]          cfg_rm1_next;
  logic [lp_shift_width-1:0]        cfg_shift_reg;

  // Per-channel state
  logic signed [gp_acc_width-1:0]   integ_reg [gp_nr_channels][gp_order];
  logic signed [gp_acc_width-1:0]   dly_reg   [gp_nr_channels][gp_order][gp_diff_delay];
  logic [lp_dec_width-1:0]          cnt_reg   [gp_nr_channels];

  // Stage between the integrators and the combs
  logic                             pipe_valid_reg;
  logic [lp_chan_width-1:0]         pipe_chan_reg;
  logic signed [gp_acc_width-1:0]   pipe_data_reg;

  logic                             chan_ok;
  logic                             accept;
  logic                             decim;
  logic [lp_chan_width-1:0]         chan_idx;
  logic signed [gp_acc_width-1:0]   inp_ext;
  logic signed [gp_acc_width-1:0]   integ_next [gp_order];
  logic signed [gp_acc_width-1:0]   comb_stage [gp_order+1];
  logic signed [lp_ext_width-1:0]   rnd_add;
  logic signed [lp_ext_width-1:0]   rnd_sum;
  logic signed [lp_ext_width-1:0]   scaled;
  logic signed [gp_oup_width-1:0]   data_next;
  logic                             sat_next;

  // Out-of-range channels are dropped; a cfg load in the same cycle also wins over the sample
  assign chan_ok  = (int'(i_chan) < gp_nr_channels);
  assign accept   = i_valid & chan_ok & ~i_cfg_load;
  assign chan_idx = chan_ok ? i_chan : '0;
  assign decim    = (cnt_reg[chan_idx] == cfg_rm1_reg);
  assign inp_ext  = {{(gp_acc_width - gp_inp_width){i_data[gp_inp_width-1]}}, i_data};

  // Clamp the requested decimation factor into 1..gp_max_decimation (stored as R-1)
  always_comb begin
    cfg_rm1_next = '0;
    if (i_cfg_decimation <= lp_dec_width'(1))
      cfg_rm1_next = '0;
    else if (i_cfg_decimation > lp_dec_width'(gp_max_decimation))
      cfg_rm1_next = lp_dec_width'(gp_max_decimation - 1);
    else
      cfg_rm1_next = i_cfg_decimation - 1'b1;
  end

  // Integrator chain of the selected channel; each stage adds the freshly updated previous stage
  always_comb begin : integ_chain
    logic signed [gp_acc_width-1:0] run;
    run = inp_ext;
    for (int k = 0; k < gp_order; k++) begin
      integ_next[k] = '0;
    end
    for (int k = 0; k < gp_order; k++) begin
      run           = integ_reg[chan_idx][k] + run;
      integ_next[k] = run;
    end
  end

  // Comb chain for the channel sitting in the pipeline register
  always_comb begin
    comb_stage[0] = pipe_data_reg;
    for (int k = 0; k < gp_order; k++) begin
      comb_stage[k+1] = comb_stage[k] - dly_reg[pipe_chan_reg][k][gp_diff_delay-1];
    end
  end

  // Round half-up, arithmetic shift, then clip to the output range
  always_comb begin
    rnd_add   = (cfg_shift_reg != '0) ? (lp_ext_width'(1) << (cfg_shift_reg - 1'b1)) : '0;
    rnd_sum   = {comb_stage[gp_order][gp_acc_width-1], comb_stage[gp_order]} + rnd_add;
    scaled    = rnd_sum >>> cfg_shift_reg;
    data_next = scaled[gp_oup_width-1:0];
    sat_next  = 1'b0;
    if (scaled > lp_oup_max) begin
      data_next = lp_oup_max[gp_oup_width-1:0];
      sat_next  = 1'b1;
    end else if (scaled < lp_oup_min) begin
      data_next = lp_oup_min[gp_oup_width-1:0];
      sat_next  = 1'b1;
    end
  end

  // Channel state, configuration and the integrator-to-comb pipeline register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_cfg_load) begin
      if (i_rst) begin
        cfg_rm1_reg   <= '0;
        cfg_shift_reg <= '0;
      end else begin
        cfg_rm1_reg   <= cfg_rm1_next;
        cfg_shift_reg <= i_cfg_shift;
      end
      pipe_valid_reg <= 1'b0;
      pipe_chan_reg  <= '0;
      pipe_data_reg  <= '0;
      for (int c = 0; c < gp_nr_channels; c++) begin
        cnt_reg[c] <= '0;
        for (int k = 0; k < gp_order; k++) begin
          integ_reg[c][k] <= '0;
          for (int j = 0; j < gp_diff_delay; j++) begin
            dly_reg[c][k][j] <= '0;
          end
        end
      end
    end else begin
      pipe_valid_reg <= accept & decim;
      if (accept) begin
        for (int k = 0; k < gp_order; k++) begin
          integ_reg[chan_idx][k] <= integ_next[k];
        end
        cnt_reg[chan_idx] <= decim ? '0 : cnt_reg[chan_idx] + 1'b1;
        if (decim) begin
          pipe_data_reg <= integ_next[gp_order-1];
          pipe_chan_reg <= chan_idx;
        end
      end
      if (pipe_valid_reg) begin
        for (int k = 0; k < gp_order; k++) begin
          dly_reg[pipe_chan_reg][k][0] <= comb_stage[k];
          for (int j = 1; j < gp_diff_delay; j++) begin
            dly_reg[pipe_chan_reg][k][j] <= dly_reg[pipe_chan_reg][k][j-1];
          end
        end
      end
    end
  end

  // Output register; a cfg load squashes whatever would have appeared next cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_chan  <= '0;
      o_data  <= '0;
      o_sat   <= 1'b0;
    end else if (i_cfg_load) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= pipe_valid_reg;
      if (pipe_valid_reg) begin
        o_chan <= pipe_chan_reg;
        o_data <= data_next;
        o_sat  <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_filt_cic_dec_mc.sv
// Testbench for filt_cic_dec_mc: reference model is the equivalent FIR
// ((1 - z^-RM) / (1 - z^-1))^N applied to each channel's input history,
// expected outputs are queued with their due cycle and compared when they appear.
module tb_filt_cic_dec_mc;

  localparam int NCH  = 3;
  localparam int N    = 3;
  localparam int M    = 1;
  localparam int MAXR = 16;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_cfg_load = 1'b0;
  logic [4:0]         i_cfg_decimation = '0;
  logic [4:0]         i_cfg_shift = '0;
  logic               i_valid = 1'b0;
  logic [1:0]         i_chan = '0;
  logic signed [7:0]  i_data = '0;
  logic               o_valid;
  logic [1:0]         o_chan;
  logic signed [15:0] o_data;
  logic               o_sat;

  filt_cic_dec_mc #(.gp_nr_channels(NCH)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_cfg_load       (i_cfg_load),
    .i_cfg_decimation (i_cfg_decimation),
    .i_cfg_shift      (i_cfg_shift),
    .i_valid          (i_valid),
    .i_chan           (i_chan),
    .i_data           (i_data),
    .o_valid          (o_valid),
    .o_chan           (o_chan),
    .o_data           (o_data),
    .o_sat            (o_sat)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    int     chan;
    longint data;
    int     sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // model state
  int hist[NCH][$];
  int cnt_m[NCH];
  int m_r = 1;
  int m_sh = 0;
  int h_arr[64];
  int h_len = 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void compute_h();
    int tmp[64];
    for (int i = 0; i < 64; i++) h_arr[i] = 0;
    h_arr[0] = 1;
    h_len = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < 64; i++) tmp[i] = 0;
      for (int i = 0; i < h_len; i++)
        for (int j = 0; j < m_r * M; j++)
          tmp[i+j] += h_arr[i];
      h_arr = tmp;
      h_len = h_len + m_r * M - 1;
    end
  endfunction

  // New config / cleared state; drop expected outputs due at or after cut_cyc
  function automatic void model_cfg(input int r, input int sh, input int cut_cyc);
    m_r  = r;
    m_sh = sh;
    for (int c = 0; c < NCH; c++) begin
      hist[c].delete();
      cnt_m[c] = 0;
    end
    compute_h();
    while (sb_q.size() > 0 && sb_q[$].cyc >= cut_cyc) void'(sb_q.pop_back());
  endfunction

  function automatic void model_accept(input int ch, input int d);
    longint y;
    longint rs;
    int     n;
    exp_t   e;
    hist[ch].push_back(d);
    cnt_m[ch]++;
    if (cnt_m[ch] == m_r) begin
      cnt_m[ch] = 0;
      n = hist[ch].size() - 1;
      y = 0;
      for (int k = 0; k < h_len && k <= n; k++) y += longint'(h_arr[k]) * longint'(hist[ch][n-k]);
      rs = y + ((m_sh > 0) ? (longint'(1) << (m_sh - 1)) : longint'(0));
      rs = rs >>> m_sh;
      e.sat = 0;
      if (rs > 32767) begin rs = 32767; e.sat = 1; end
      else if (rs < -32768) begin rs = -32768; e.sat = 1; end
      e.cyc  = cyc + 2;
      e.chan = ch;
      e.data = rs;
      sb_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int ch, input int d);
    i_valid = 1'b1;
    i_chan  = 2'(ch);
    i_data  = 8'(d);
    if (ch < NCH) model_accept(ch, d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic load(input int dec, input int sh, input bit with_valid);
    int r;
    r = (dec <= 1) ? 1 : ((dec > MAXR) ? MAXR : dec);
    i_cfg_load       = 1'b1;
    i_cfg_decimation = 5'(dec);
    i_cfg_shift      = 5'(sh);
    i_valid          = with_valid;
    i_chan           = 2'd0;
    i_data           = 8'sd7;
    model_cfg(r, sh, cyc + 1);
    tick();
    i_cfg_load = 1'b0;
    i_valid    = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_o_data"}, o_data, 0);
    chk({tag, "_o_chan"}, o_chan, 0);
    chk({tag, "_o_sat"}, o_sat, 0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      chk("o_valid_due", o_valid, 1);
      if (o_valid) begin
        $display("out cyc=%0d ch=%0d data=%0d sat=%0d (exp ch=%0d data=%0d sat=%0d)",
                 cyc, o_chan, o_data, o_sat, sb_q[0].chan, sb_q[0].data, sb_q[0].sat);
        chk("o_chan", o_chan, sb_q[0].chan);
        chk("o_data", o_data, sb_q[0].data);
        chk("o_sat", o_sat, sb_q[0].sat);
      end
      void'(sb_q.pop_front());
    end else if (o_valid) begin
      chk("o_valid_unexpected", o_valid, 0);
    end
  end

  initial begin
    model_cfg(1, 0, 0);
    idle(3);
    chk_zero_outputs("reset");
    i_rst = 1'b0;
    tick();

    // reset cfg is R=1, shift=0: output equals input
    send(0, 5); send(1, -3); send(2, 127);
    idle(4);

    // impulse, R=4 shift=0 -> 10, 6, 0, 0
    load(4, 0, 1'b0);
    send(0, 1);
    repeat (15) send(0, 0);
    idle(4);

    // DC +1 with shift 6 then shift 0
    load(4, 6, 1'b0);
    repeat (32) send(0, 1);
    idle(4);
    load(4, 0, 1'b0);
    repeat (32) send(0, 1);
    idle(4);

    // DC -128 at R=16 (requested 20, clamped), saturating; then exact with shift 4
    load(20, 0, 1'b0);
    repeat (64) send(0, -128);
    idle(4);
    load(16, 4, 1'b0);
    repeat (64) send(0, -128);
    idle(4);

    // R=0 clamps to 1
    load(0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send(1, i * 10 - 20);
    idle(4);

    // interleaved channels, no cross-talk
    load(4, 0, 1'b0);
    for (int i = 0; i < 64; i++) send(i % 2, (i % 2) ? -1 : 1);
    idle(4);

    // cfg load with a valid sample right after a decimated sample
    load(4, 0, 1'b0);
    send(0, 1); send(0, 0); send(0, 0); send(0, 0);
    load(2, 0, 1'b1);
    send(0, 1);
    repeat (7) send(0, 0);
    idle(4);

    // random mix of channels, gaps and invalid channel
    load(3, 2, 1'b0);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
      else
        idle(1);
    end
    idle(4);

    // reset right after a decimated accept: in-flight output must vanish
    load(4, 0, 1'b0);
    send(0, 3); send(0, 1); send(0, 2); send(0, 4);
    i_rst = 1'b1;
    model_cfg(1, 0, cyc);
    #2;
    chk_zero_outputs("midreset");
    idle(3);
    i_rst = 1'b0;
    tick();
    send(0, 9); send(3, 100); send(0, -9);
    idle(4);

    // invalid channel interleaved into an impulse must not disturb state
    load(4, 0, 1'b0);
    send(0, 1); send(3, 100); send(0, 0); send(3, -50);
    repeat (14) send(0, 0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
